memory_arbiter: RTL and testbench

Memory-side responder for the cache request interface: accepts word requests from the instruction cache (iREN) and data cache (dREN/dWEN), arbitrates them onto the single-ported RAM, and returns iwait/dwait and iload/dload. It sits between the two caches and the RAM model. It is the other end of the handshake the data cache drives during fills, write-backs and the flush hit-count store. Data requests have priority, with a bounded-starvation rule for instruction fetches.

---
 rtl/memory_arbiter.sv | 99 +++++++++
 tb/tb_memory_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Arbitrates instruction- and data-cache word requests onto a single-ported RAM.
// Data wins by default; after STREAK_MAX data grants a pending fetch is forced through.
module memory_arbiter #(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned STREAK_MAX = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate
);

   localparam int unsigned STREAK_W = (STREAK_MAX > 0) ? $clog2(STREAK_MAX + 1) : 1;
   localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);
   localparam logic [1:0] RAM_ACCESS = 2'b10;

   typedef enum logic [1:0] {StIdle, StDGrant, StIGrant} state_e;

   state_e              r_state, w_state_next;
   logic [STREAK_W-1:0] r_streak, w_streak_next;
   logic                w_dreq, w_access, w_forced;

   assign w_dreq   = dREN | dWEN;
   assign w_access = (ramstate == RAM_ACCESS);
   assign w_forced = iREN && (r_streak == STREAK_LIM);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= StIdle;
         r_streak <= '0;
      end else begin
         r_state  <= w_state_next;
         r_streak <= w_streak_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_streak_next = r_streak;
      ramREN        = 1'b0;
      ramWEN        = 1'b0;
      ramaddr       = '0;
      ramstore      = '0;
      iwait         = 1'b1;
      dwait         = 1'b1;
      iload         = '0;
      dload         = '0;
      unique case (r_state)
         StIdle: begin
            if (!iREN) w_streak_next = '0;
            if (w_dreq && !w_forced) w_state_next = StDGrant;
            else if (iREN)           w_state_next = StIGrant;
         end
         StDGrant: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            // A withdrawn request never completes, even if the RAM reports ACCESS.
            if (!w_dreq) begin
               w_state_next = StIdle;
            end else if (w_access) begin
               dwait        = 1'b0;
               dload        = ramload;
               w_state_next = StIdle;
               if (r_streak != STREAK_LIM) w_streak_next = r_streak + STREAK_W'(1);
            end
         end
         StIGrant: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (!iREN) begin
               w_state_next = StIdle;
            end else if (w_access) begin
               iwait         = 1'b0;
               iload         = ramload;
               w_state_next  = StIdle;
               w_streak_next = '0;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: inputs change on the falling edge, outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_memory_arbiter;

   localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

   logic        CLK, nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic [3:0]  ctl;

   int n_chk  = 0;
   int n_pass = 0;

   assign ctl = {ramREN, ramWEN, iwait, dwait};

   memory_arbiter #(.WORD_W(32), .STREAK_MAX(2)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic drop_all();
      @(negedge CLK);
      iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_chk++; if (ctl !== 4'b0011) $display("FAIL rst_ctl: got %b want 0011", ctl); else n_pass++;
      n_chk++; if (ramaddr !== 32'h0) $display("FAIL rst_addr: got %h want 0", ramaddr); else n_pass++;
      n_chk++; if (ramstore !== 32'h0) $display("FAIL rst_store: got %h want 0", ramstore); else n_pass++;
      n_chk++; if ({iload, dload} !== 64'h0) $display("FAIL rst_loads: got %h want 0", {iload, dload}); else n_pass++;
      @(negedge CLK); nRST = 1; #1;
      n_chk++; if (ctl !== 4'b0011) $display("FAIL rst_release_ctl: got %b want 0011", ctl); else n_pass++;
   endtask

   task automatic test_single_read();
      @(negedge CLK); dREN = 1; daddr = 32'h40; ramstate = BUSY; ramload = 32'h0; #1;
      n_chk++; if (ctl !== 4'b0011) $display("FAIL rd_idle: got %b want 0011", ctl); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK); #1;
         n_chk++; if (ctl !== 4'b1011) $display("FAIL rd_busy%0d: got %b want 1011", i, ctl); else n_pass++;
         n_chk++; if (ramaddr !== 32'h40) $display("FAIL rd_addr%0d: got %h want 40", i, ramaddr); else n_pass++;
         n_chk++; if (dload !== 32'h0) $display("FAIL rd_dload_busy%0d: got %h want 0", i, dload); else n_pass++;
      end
      @(negedge CLK); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
      n_chk++; if (ctl !== 4'b1010) $display("FAIL rd_done: got %b want 1010", ctl); else n_pass++;
      n_chk++; if (dload !== 32'hDEADBEEF) $display("FAIL rd_dload: got %h want deadbeef", dload); else n_pass++;
      @(negedge CLK); dREN = 0; ramstate = FREE; #1;
      n_chk++; if (ctl !== 4'b0011) $display("FAIL rd_back_idle: got %b want 0011", ctl); else n_pass++;
      n_chk++; if (dload !== 32'h0) $display("FAIL rd_dload_idle: got %h want 0", dload); else n_pass++;
   endtask

   task automatic test_write_priority();
      @(negedge CLK); dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678; ramstate = BUSY; #1;
      n_chk++; if (ctl !== 4'b0011) $display("FAIL wr_idle: got %b want 0011", ctl); else n_pass++;
      @(negedge CLK); #1;
      n_chk++; if (ctl !== 4'b0111) $display("FAIL wr_busy: got %b want 0111", ctl); else n_pass++;
      n_chk++; if (ramstore !== 32'h12345678) $display("FAIL wr_store: got %h want 12345678", ramstore); else n_pass++;
      n_chk++; if (ramaddr !== 32'h80) $display("FAIL wr_addr: got %h want 80", ramaddr); else n_pass++;
      @(negedge CLK); ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
      n_chk++; if (ctl !== 4'b0110) $display("FAIL wr_done: got %b want 0110", ctl); else n_pass++;
      n_chk++; if (dload !== 32'hCAFEF00D) $display("FAIL wr_dload: got %h want cafef00d", dload); else n_pass++;
      drop_all();
      n_chk++; if ({ctl, ramstore} !== {4'b0011, 32'h0}) $display("FAIL wr_back_idle: got %b/%h want 0011/0", ctl, ramstore); else n_pass++;
   endtask

   task automatic test_contention();
      logic [3:0]  exp_ctl;
      logic [31:0] exp_addr;
      @(negedge CLK);
      iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h200; ramstate = ACCESS; ramload = 32'hA5A50001;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge CLK);
         #1;
         if (i % 2 == 0) begin
            exp_ctl = 4'b0011; exp_addr = 32'h0;
         end else if (i == 5 || i == 11) begin
            exp_ctl = 4'b1001; exp_addr = 32'h100;
         end else begin
            exp_ctl = 4'b1010; exp_addr = 32'h200;
         end
         n_chk++; if (ctl !== exp_ctl) $display("FAIL cont_ctl%0d: got %b want %b", i, ctl, exp_ctl); else n_pass++;
         n_chk++; if (ramaddr !== exp_addr) $display("FAIL cont_addr%0d: got %h want %h", i, ramaddr, exp_addr); else n_pass++;
         if (exp_ctl == 4'b1001) begin
            n_chk++; if (iload !== 32'hA5A50001) $display("FAIL cont_iload%0d: got %h want a5a50001", i, iload); else n_pass++;
         end
      end
      drop_all();
   endtask

   task automatic test_withdrawal();
      @(negedge CLK); iREN = 1; iaddr = 32'h104; dREN = 1; daddr = 32'h60; ramstate = ACCESS; ramload = 32'h11; #1;
      @(negedge CLK); #1;
      n_chk++; if (ctl !== 4'b1010) $display("FAIL wd_first: got %b want 1010", ctl); else n_pass++;
      @(negedge CLK); ramstate = BUSY; #1;
      @(negedge CLK); #1;
      n_chk++; if (ctl !== 4'b1011) $display("FAIL wd_busy: got %b want 1011", ctl); else n_pass++;
      @(negedge CLK); dREN = 0; #1;
      n_chk++; if ({ctl, ramaddr} !== {4'b0011, 32'h60}) $display("FAIL wd_drop: got %b/%h want 0011/60", ctl, ramaddr); else n_pass++;
      @(negedge CLK); dREN = 1; ramstate = ACCESS; #1;
      n_chk++; if ({ctl, ramaddr} !== {4'b0011, 32'h0}) $display("FAIL wd_idle: got %b/%h want 0011/0", ctl, ramaddr); else n_pass++;
      // Streak is still 1, so one more data grant precedes the forced fetch.
      @(negedge CLK); #1;
      n_chk++; if (ctl !== 4'b1010) $display("FAIL wd_second: got %b want 1010", ctl); else n_pass++;
      @(negedge CLK); @(negedge CLK); #1;
      n_chk++; if ({ctl, ramaddr} !== {4'b1001, 32'h104}) $display("FAIL wd_forced: got %b/%h want 1001/104", ctl, ramaddr); else n_pass++;
      drop_all();
   endtask

   task automatic test_error();
      @(negedge CLK); dREN = 1; daddr = 32'h300; ramstate = ERROR; ramload = 32'h5555AAAA; #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK); #1;
         n_chk++; if ({ctl, dload} !== {4'b1011, 32'h0}) $display("FAIL err_hold%0d: got %b/%h want 1011/0", i, ctl, dload); else n_pass++;
      end
      @(negedge CLK); ramstate = ACCESS; #1;
      n_chk++; if ({ctl, dload} !== {4'b1010, 32'h5555AAAA}) $display("FAIL err_done: got %b/%h want 1010/5555aaaa", ctl, dload); else n_pass++;
      drop_all();
   endtask

   task automatic test_reset_mid_igrant();
      @(negedge CLK); iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h50; ramstate = ACCESS; ramload = 32'h77; #1;
      @(negedge CLK); @(negedge CLK); @(negedge CLK); #1;
      n_chk++; if (ctl !== 4'b1010) $display("FAIL rmi_d2: got %b want 1010", ctl); else n_pass++;
      @(negedge CLK); ramstate = BUSY; #1;
      @(negedge CLK); #1;
      n_chk++; if ({ctl, ramaddr} !== {4'b1011, 32'h44}) $display("FAIL rmi_igrant: got %b/%h want 1011/44", ctl, ramaddr); else n_pass++;
      nRST = 0; #1;
      n_chk++; if ({ctl, ramaddr} !== {4'b0011, 32'h0}) $display("FAIL rmi_async: got %b/%h want 0011/0", ctl, ramaddr); else n_pass++;
      @(negedge CLK); nRST = 1; ramstate = ACCESS; #1;
      n_chk++; if ({ctl, ramaddr} !== {4'b0011, 32'h0}) $display("FAIL rmi_idle: got %b/%h want 0011/0", ctl, ramaddr); else n_pass++;
      // Streak cleared by reset: data wins instead of a forced fetch.
      @(negedge CLK); #1;
      n_chk++; if ({ctl, ramaddr} !== {4'b1010, 32'h50}) $display("FAIL rmi_streak: got %b/%h want 1010/50", ctl, ramaddr); else n_pass++;
      drop_all();
   endtask

   initial begin
      nRST = 0; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
      test_reset();
      test_single_read();
      test_write_priority();
      test_contention();
      test_withdrawal();
      test_error();
      test_reset_mid_igrant();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
